// File: rtl/north_skew_scheduler.sv
// Feeds the top row of a systolic array from per-column north FIFOs, issuing
// reads on a one-step diagonal skew so column i starts i steps after column 0.
module north_skew_scheduler #(
    parameter int COL    = 3,
    parameter int W_DATA = 8,
    parameter int W_LEN  = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic [W_LEN-1:0]        i_len,
    input  logic                    i_stall,
    input  logic [COL-1:0]          i_fifo_empty,
    input  logic [COL-1:0]          i_fifo_dv,
    input  logic [COL*W_DATA-1:0]   i_fifo_data,
    output logic [COL-1:0]          o_read_enable,
    output logic [COL*W_DATA-1:0]   o_pe_data,
    output logic [COL-1:0]          o_pe_valid,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_underflow,
    output logic [1:0]              o_dbg_state
);

    // Step counter is wide enough for L+COL-1 with a spare bit, so it never wraps.
    localparam int T_W = W_LEN + $clog2(COL) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [W_LEN-1:0] len_q;
    logic [T_W-1:0]   t_q;
    logic [T_W-1:0]   t_next;
    logic [T_W-1:0]   last_t;
    logic [COL-1:0]   due;
    logic [COL-1:0]   re_q;
    logic             advance;

    assign o_dbg_state = state;
    assign t_next      = t_q + T_W'(1);
    assign last_t      = T_W'(len_q) + T_W'(COL - 1);

    always_comb begin
        due = '0;
        for (int i = 0; i < COL; i++) begin
            if (state == RUN && t_q >= T_W'(i) && t_q < T_W'(i) + T_W'(len_q)) begin
                due[i] = 1'b1;
            end
        end
    end

    // A step is all-or-nothing: any empty due column or a stall holds every column.
    assign advance       = (state == RUN) && !i_stall && ((due & i_fifo_empty) == '0);
    assign o_read_enable = advance ? due : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            len_q  <= '0;
            t_q    <= '0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start && i_len != '0) begin
                        state  <= RUN;
                        len_q  <= i_len;
                        t_q    <= '0;
                        o_busy <= 1'b1;
                    end
                end
                RUN: begin
                    if (advance) begin
                        t_q <= t_next;
                        if (t_next == last_t) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    state  <= DONE;
                    o_busy <= 1'b0;
                    o_done <= 1'b1;
                end
                DONE: begin
                    state  <= IDLE;
                    o_done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Capture path runs every cycle so in-flight data lands even after RUN ends.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pe_data   <= '0;
            o_pe_valid  <= '0;
            re_q        <= '0;
            o_underflow <= 1'b0;
        end else begin
            o_pe_valid <= i_fifo_dv;
            re_q       <= o_read_enable;
            for (int i = 0; i < COL; i++) begin
                if (i_fifo_dv[i]) begin
                    o_pe_data[W_DATA*(COL-i)-1 -: W_DATA] <= i_fifo_data[W_DATA*(COL-i)-1 -: W_DATA];
                end
            end
            if ((re_q & ~i_fifo_dv) != '0) begin
                o_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_north_skew_scheduler.sv
// Bench for north_skew_scheduler: FIFO model answers reads one cycle later and
// queues the data it returns; captured top-row data is popped against that queue.
module tb_north_skew_scheduler;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_start;
    logic [7:0]  i_len;
    logic        i_stall;
    logic [2:0]  i_fifo_empty;
    logic [2:0]  i_fifo_dv;
    logic [23:0] i_fifo_data;
    logic [2:0]  o_read_enable;
    logic [23:0] o_pe_data;
    logic [2:0]  o_pe_valid;
    logic        o_busy;
    logic        o_done;
    logic        o_underflow;
    logic [1:0]  o_dbg_state;

    int n_pass  = 0;
    int n_total = 0;

    logic [9:0] exp_q[$];
    logic [7:0] data_cnt;
    logic       withhold_arm;
    logic       withheld;

    north_skew_scheduler #(.COL(3), .W_DATA(8), .W_LEN(8)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_len        (i_len),
        .i_stall      (i_stall),
        .i_fifo_empty (i_fifo_empty),
        .i_fifo_dv    (i_fifo_dv),
        .i_fifo_data  (i_fifo_data),
        .o_read_enable(o_read_enable),
        .o_pe_data    (o_pe_data),
        .o_pe_valid   (o_pe_valid),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_underflow  (o_underflow),
        .o_dbg_state  (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ---------------- FIFO model ----------------
    always @(posedge i_clk) begin
        if (!i_rst_n) begin
            i_fifo_dv <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (o_read_enable[i] && i == 1 && withhold_arm && !withheld) begin
                    i_fifo_dv[i] <= 1'b0;
                    withheld     <= 1'b1;
                end else if (o_read_enable[i]) begin
                    i_fifo_dv[i] <= 1'b1;
                    i_fifo_data[8*(3-i)-1 -: 8] <= 8'(data_cnt + 8'(i));
                    exp_q.push_back({2'(i), 8'(data_cnt + 8'(i))});
                end else begin
                    i_fifo_dv[i] <= 1'b0;
                end
            end
            data_cnt <= data_cnt + 8'd7;
        end
    end

    // ---------------- driver: one cycle, scoreboard pops captured data ----------------
    task automatic clock_cycle();
        logic [9:0] e;
        logic [9:0] got;
        @(negedge i_clk);
        if (i_rst_n) begin
            for (int i = 0; i < 3; i++) begin
                if (o_pe_valid[i]) begin
                    got = {2'(i), o_pe_data[8*(3-i)-1 -: 8]};
                    n_total++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL pe_data_unexpected: got col%0d data %h, expected no valid", i, got[7:0]);
                    end else begin
                        e = exp_q.pop_front();
                        if (got !== e) $display("FAIL pe_data: got %h, expected %h", got, e);
                        else n_pass++;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic start_pass(input logic [7:0] len);
        i_len   = len;
        i_start = 1'b1;
        clock_cycle();
        i_start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        n_total++; if (o_read_enable !== 3'b000) $display("FAIL reset_re: got %b expected 000", o_read_enable); else n_pass++;
        n_total++; if (o_pe_data !== 24'h0) $display("FAIL reset_pe_data: got %h expected 0", o_pe_data); else n_pass++;
        n_total++; if (o_pe_valid !== 3'b000) $display("FAIL reset_pe_valid: got %b expected 000", o_pe_valid); else n_pass++;
        n_total++; if ({o_busy, o_done, o_underflow} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {o_busy, o_done, o_underflow}); else n_pass++;
        n_total++; if (o_dbg_state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", o_dbg_state); else n_pass++;
        i_rst_n = 1'b1;
        clock_cycle();
        n_total++; if (o_dbg_state !== 2'd0) $display("FAIL reset_idle_after: got %0d expected 0", o_dbg_state); else n_pass++;
    endtask

    task automatic test_basic();
        logic [2:0] pat [4];
        pat = '{3'b001, 3'b011, 3'b110, 3'b100};
        start_pass(8'd2);
        for (int k = 0; k < 4; k++) begin
            #1;
            n_total++; if (o_read_enable !== pat[k]) $display("FAIL basic_re step%0d: got %b expected %b", k, o_read_enable, pat[k]); else n_pass++;
            n_total++; if (o_busy !== 1'b1) $display("FAIL basic_busy step%0d: got %b expected 1", k, o_busy); else n_pass++;
            clock_cycle();
        end
        #1;
        n_total++; if ({o_read_enable, o_dbg_state, o_busy, o_done} !== {3'b000, 2'd2, 1'b1, 1'b0}) $display("FAIL basic_drain: got re=%b st=%0d busy=%b done=%b expected re=000 st=2 busy=1 done=0", o_read_enable, o_dbg_state, o_busy, o_done); else n_pass++;
        clock_cycle();
        n_total++; if ({o_busy, o_done} !== 2'b01) $display("FAIL basic_done: got busy/done %b expected 01", {o_busy, o_done}); else n_pass++;
        clock_cycle();
        n_total++; if ({o_dbg_state, o_done} !== {2'd0, 1'b0}) $display("FAIL basic_idle: got st=%0d done=%b expected st=0 done=0", o_dbg_state, o_done); else n_pass++;
        n_total++; if (o_underflow !== 1'b0) $display("FAIL basic_underflow: got %b expected 0", o_underflow); else n_pass++;
    endtask

    task automatic test_stall();
        logic [2:0] pat [6];
        pat = '{3'b001, 3'b000, 3'b000, 3'b011, 3'b110, 3'b100};
        start_pass(8'd2);
        for (int k = 0; k < 6; k++) begin
            i_stall = (k == 1 || k == 2);
            #1;
            n_total++; if (o_read_enable !== pat[k]) $display("FAIL stall_re cyc%0d: got %b expected %b", k, o_read_enable, pat[k]); else n_pass++;
            clock_cycle();
        end
        i_stall = 1'b1;  // stall has no effect while draining
        #1;
        n_total++; if (o_dbg_state !== 2'd2) $display("FAIL stall_drain: got st=%0d expected 2", o_dbg_state); else n_pass++;
        clock_cycle();
        n_total++; if (o_done !== 1'b1) $display("FAIL stall_done: got %b expected 1", o_done); else n_pass++;
        i_stall = 1'b0;
        clock_cycle();
    endtask

    task automatic test_empty();
        logic [2:0] pat [7];
        logic [2:0] emp [7];
        pat = '{3'b001, 3'b011, 3'b000, 3'b000, 3'b000, 3'b110, 3'b100};
        emp = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b000};
        start_pass(8'd2);
        for (int k = 0; k < 7; k++) begin
            i_fifo_empty = emp[k];
            #1;
            n_total++; if (o_read_enable !== pat[k]) $display("FAIL empty_re cyc%0d: got %b expected %b", k, o_read_enable, pat[k]); else n_pass++;
            clock_cycle();
        end
        n_total++; if (o_dbg_state !== 2'd2) $display("FAIL empty_drain: got st=%0d expected 2", o_dbg_state); else n_pass++;
        repeat (2) clock_cycle();
    endtask

    task automatic test_ignore();
        logic [2:0] pat [4];
        pat = '{3'b001, 3'b011, 3'b110, 3'b100};
        start_pass(8'd0);
        #1;
        n_total++; if ({o_dbg_state, o_busy, o_read_enable} !== {2'd0, 1'b0, 3'b000}) $display("FAIL ignore_len0: got st=%0d busy=%b re=%b expected st=0 busy=0 re=000", o_dbg_state, o_busy, o_read_enable); else n_pass++;
        start_pass(8'd2);
        for (int k = 0; k < 4; k++) begin
            i_start = (k == 0);
            i_len   = (k == 0) ? 8'd5 : 8'd2;
            #1;
            n_total++; if (o_read_enable !== pat[k]) $display("FAIL ignore_run_re step%0d: got %b expected %b", k, o_read_enable, pat[k]); else n_pass++;
            clock_cycle();
        end
        i_start = 1'b0;
        n_total++; if (o_dbg_state !== 2'd2) $display("FAIL ignore_run_drain: got st=%0d expected 2", o_dbg_state); else n_pass++;
        repeat (2) clock_cycle();
    endtask

    task automatic test_underflow();
        withhold_arm = 1'b1;
        start_pass(8'd2);
        repeat (5) clock_cycle();
        n_total++; if ({o_done, o_underflow} !== 2'b11) $display("FAIL underflow_set: got done/uf %b expected 11", {o_done, o_underflow}); else n_pass++;
        clock_cycle();
        start_pass(8'd1);
        repeat (6) clock_cycle();
        n_total++; if ({o_dbg_state, o_underflow} !== {2'd0, 1'b1}) $display("FAIL underflow_sticky: got st=%0d uf=%b expected st=0 uf=1", o_dbg_state, o_underflow); else n_pass++;
    endtask

    task automatic test_reset_mid_pass();
        logic [2:0] pat [3];
        pat = '{3'b001, 3'b010, 3'b100};
        start_pass(8'd2);
        repeat (2) clock_cycle();
        #1;
        n_total++; if (o_read_enable !== 3'b110) $display("FAIL midrst_pre: got %b expected 110", o_read_enable); else n_pass++;
        i_rst_n = 1'b0;
        #1;
        n_total++; if ({o_read_enable, o_pe_valid, o_busy, o_done, o_underflow, o_dbg_state} !== 11'b0) $display("FAIL midrst_outputs: got re=%b v=%b busy=%b done=%b uf=%b st=%0d expected all 0", o_read_enable, o_pe_valid, o_busy, o_done, o_underflow, o_dbg_state); else n_pass++;
        n_total++; if (o_pe_data !== 24'h0) $display("FAIL midrst_pe_data: got %h expected 0", o_pe_data); else n_pass++;
        repeat (2) clock_cycle();
        exp_q.delete();
        i_rst_n = 1'b1;
        clock_cycle();
        n_total++; if (o_dbg_state !== 2'd0) $display("FAIL midrst_wait_idle: got st=%0d expected 0", o_dbg_state); else n_pass++;
        start_pass(8'd1);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_total++; if (o_read_enable !== pat[k]) $display("FAIL midrst_l1_re step%0d: got %b expected %b", k, o_read_enable, pat[k]); else n_pass++;
            clock_cycle();
        end
        n_total++; if (o_dbg_state !== 2'd2) $display("FAIL midrst_l1_drain: got st=%0d expected 2", o_dbg_state); else n_pass++;
        clock_cycle();
        n_total++; if (o_done !== 1'b1) $display("FAIL midrst_l1_done: got %b expected 1", o_done); else n_pass++;
        repeat (2) clock_cycle();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        i_rst_n      = 1'b0;
        i_start      = 1'b0;
        i_len        = 8'd0;
        i_stall      = 1'b0;
        i_fifo_empty = 3'b000;
        i_fifo_data  = 24'h0;
        data_cnt     = 8'h10;
        withhold_arm = 1'b0;
        withheld     = 1'b0;
        repeat (2) @(negedge i_clk);
        test_reset();
        test_basic();
        test_stall();
        test_empty();
        test_ignore();
        test_underflow();
        test_reset_mid_pass();
        n_total++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/north_skew_scheduler.md
NORTH_SKEW_SCHEDULER -- requirements
Module: north_skew_scheduler

Interface
REQ-001 Parameter COL, default 3: number of array columns, one north FIFO per column.
REQ-002 Parameter W_DATA, default 8: data width per column.
REQ-003 Parameter W_LEN, default 8: width of the per-column element count.
REQ-004 i_clk  in  1: single clock; all state on the rising edge.
REQ-005 i_rst_n  in  1: reset, asynchronous, active-low.
REQ-006 i_start  in  1: one-cycle request to start a feed pass.
REQ-007 i_len  in  W_LEN: elements to read per column; sampled only on an accepted start.
REQ-008 i_stall  in  1: array backpressure; freezes the schedule while high.
REQ-009 i_fifo_empty  in  COL: per-column FIFO empty flags.
REQ-010 i_fifo_dv  in  COL: per-column FIFO read-data-valid flags.
REQ-011 i_fifo_data  in  COL*W_DATA: FIFO data; column i occupies bits [W_DATA*(COL-i)-1 -: W_DATA], so column 0 is in the MSBs.
REQ-012 o_read_enable  out  COL: per-column FIFO read strobes.
REQ-013 o_pe_data  out  COL*W_DATA: registered data to the array top row, packed as in REQ-011.
REQ-014 o_pe_valid  out  COL: per-column valid for o_pe_data.
REQ-015 o_busy  out  1: high from the cycle after an accepted start until o_done.
REQ-016 o_done  out  1: one-cycle pulse at the end of a pass.
REQ-017 o_underflow  out  1: sticky error flag.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-019 IDLE->RUN when i_start=1 and i_len!=0; the block latches L=i_len and clears step counter t to 0.
REQ-020 i_start with i_len=0, or any i_start outside IDLE, SHALL be ignored.
REQ-021 t SHALL be W_LEN+clog2(COL)+1 bits wide and never wrap within a pass.
REQ-022 In RUN, column i is due at step t iff i <= t <= i+L-1; this produces a one-step diagonal skew per column.
REQ-023 An advance occurs when i_stall=0 and no due column has i_fifo_empty=1.
REQ-024 On an advance, o_read_enable[i]=1 for every due column and t increments by 1; otherwise o_read_enable=0 and t holds.
REQ-025 o_read_enable SHALL be combinational from state, t, i_stall and i_fifo_empty, and SHALL be 0 outside RUN.
REQ-026 RUN->DRAIN on the advance that makes t = L+COL-1; DRAIN->DONE after exactly 1 cycle; DONE->IDLE after 1 cycle.
REQ-027 o_done=1 only in DONE; o_busy=1 in RUN and DRAIN.
REQ-028 Each cycle, o_pe_valid[i] <= i_fifo_dv[i]; o_pe_data column i loads i_fifo_data column i when i_fifo_dv[i]=1, otherwise it holds.
REQ-029 The FIFO SHALL return dv exactly one cycle after re; a column with re=1 at cycle n and dv=0 at n+1 sets o_underflow.
REQ-030 o_underflow is cleared only by reset.
REQ-031 i_stall and empty gating SHALL never split a step, so every column advances together and the skew is preserved.
REQ-032 i_stall has no effect in DRAIN or DONE; in-flight dv is still captured.

Reset
REQ-033 While i_rst_n=0 the block SHALL be in IDLE with t=0, L=0, o_read_enable=0, o_pe_data=0, o_pe_valid=0, o_busy=0, o_done=0 and o_underflow=0.
REQ-034 Reset asserted mid-pass SHALL abort immediately with no further reads; after release the block waits in IDLE for a new start.

Verification
REQ-035 COL=3, L=2, FIFOs non-empty, no stall: start -> o_read_enable over 4 RUN cycles = 001, 011, 110, 100 (bit0=col0); then 1 DRAIN cycle; o_done pulses on the next cycle.
REQ-036 Same stimulus with i_stall=1 for 2 cycles at t=1 -> the 011 pattern is delayed 2 cycles, o_read_enable=0 while stalled, and the total pass is 2 cycles longer.
REQ-037 Col2 FIFO empty at t=2 for 3 cycles -> o_read_enable=000 and t holds for 3 cycles, then resumes with 110.
REQ-038 FIFO model withholds dv after one col1 read -> o_underflow=1 and stays 1 through later passes until reset.
REQ-039 i_start with i_len=0, and i_start during RUN -> no reads, state unchanged.
REQ-040 Reset asserted at t=2 -> o_read_enable=000 and all outputs zero immediately; a new start with L=1 then gives 001, 010, 100.
